// File: rtl/sm2201_bus_receiver.sv
// Receive side of the SM2201 hex bus driver: sync, qualify stable words, queue them.
// Latency: data change to rd_valid = SYNC_STAGES + STABLE_CYCLES + 1 edges (6 with defaults).
// Backpressure: rd_valid/rd_ready pop; a qualified word arriving while full and not popping is dropped (sticky overflow).
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   e1, e2               remote driver enables, active-low, asynchronous
//   data                 remote driver lines, asynchronous, may be X/Z while disabled
//   rd_data, rd_valid    registered FIFO head and non-empty flag
//   rd_ready             consumer accepts head when rd_valid is also high
//   count                words currently held (0..DEPTH)
//   overflow             sticky dropped-word flag, cleared by clr_overflow (set wins)
//   drop_count           8-bit saturating drop counter, only when SM2201_RX_DROP_COUNT_EN is defined
module sm2201_bus_receiver #(
  parameter int WIDTH         = 6,
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     e1,
  input  logic                     e2,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
`ifdef SM2201_RX_DROP_COUNT_EN
  ,
  output logic [7:0]               drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_ONE = SW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers. Enables reset to the disabled (high) level.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]            r_e1_sync;
  logic [SYNC_STAGES-1:0]            r_e2_sync;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_data_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e1_sync   <= '1;
      r_e2_sync   <= '1;
      r_data_sync <= '0;
    end else begin
      r_e1_sync   <= {r_e1_sync[SYNC_STAGES-2:0], e1};
      r_e2_sync   <= {r_e2_sync[SYNC_STAGES-2:0], e2};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data};
    end
  end

  logic             w_e1_s;
  logic             w_e2_s;
  logic [WIDTH-1:0] w_data_s;

  assign w_e1_s   = r_e1_sync[SYNC_STAGES-1];
  assign w_e2_s   = r_e2_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Qualifier: stability run length plus capture FSM.
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [SW-1:0]    r_stab;
  logic [WIDTH-1:0] r_data_prev;
  logic             r_push_vld;
  logic [WIDTH-1:0] r_push_dat;

  logic             w_open;
  logic             w_same;
  logic [SW-1:0]    w_stab_nxt;
  logic             w_hit;

  assign w_open = ~w_e1_s & ~w_e2_s;
  assign w_same = (w_data_s == r_data_prev);

  // Run length of identical open-window samples. A changed sample is itself the
  // first sample of a new run, so window-open and data-change paths qualify
  // after the same number of samples.
  always_comb begin
    w_stab_nxt = '0;
    if (!w_open)
      w_stab_nxt = '0;
    else if (!w_same)
      w_stab_nxt = STAB_ONE;
    else if (r_stab == STAB_MAX)
      w_stab_nxt = r_stab;
    else
      w_stab_nxt = r_stab + STAB_ONE;
  end

  // In HOLD the saturated run belongs to the already-captured word; only a new
  // value (which restarts the run) may qualify again.
  assign w_hit = w_open && (w_stab_nxt == STAB_MAX) &&
                 ((r_state != ST_HOLD) || !w_same);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_stab      <= '0;
      r_data_prev <= '0;
      r_push_vld  <= 1'b0;
      r_push_dat  <= '0;
    end else begin
      r_stab      <= w_stab_nxt;
      r_data_prev <= w_data_s;
      r_push_vld  <= w_hit;
      if (w_hit)
        r_push_dat <= w_data_s;

      case (r_state)
        ST_IDLE: begin
          if (w_hit)       r_state <= ST_HOLD;
          else if (w_open) r_state <= ST_QUAL;
        end
        ST_QUAL: begin
          if (!w_open)     r_state <= ST_IDLE;
          else if (w_hit)  r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!w_open)     r_state <= ST_IDLE;
          else if (w_hit)  r_state <= ST_HOLD;
          else if (!w_same) r_state <= ST_QUAL;
        end
        default:           r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO with registered head.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_overflow;

  logic             w_pop;
  logic             w_full;
  logic             w_wr_en;
  logic             w_drop;
  logic [AW-1:0]    w_rd_ptr_n;
  logic [CW-1:0]    w_count_n;
  logic [WIDTH-1:0] w_head_n;

  assign w_pop      = r_rd_valid & rd_ready;
  assign w_full     = (r_count == DEPTH_C);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr_en    = r_push_vld & (~w_full | w_pop);
  assign w_drop     = r_push_vld & w_full & ~w_pop;
  assign w_rd_ptr_n = r_rd_ptr + AW'(w_pop);
  assign w_count_n  = r_count + CW'(w_wr_en) - CW'(w_pop);
  // The write slot can only coincide with the next head when the FIFO is
  // otherwise empty, so bypass the incoming word straight into the head.
  assign w_head_n   = (w_wr_en && (r_wr_ptr == w_rd_ptr_n)) ? r_push_dat
                                                            : r_mem[w_rd_ptr_n];

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= r_push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr   <= w_rd_ptr_n;
      r_count    <= w_count_n;
      r_rd_valid <= (w_count_n != '0);
      r_rd_data  <= w_head_n;
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clr_overflow)
        r_overflow <= 1'b0;
    end
  end

`ifdef SM2201_RX_DROP_COUNT_EN
  logic [7:0] r_drop_cnt;

  // A drop in the clear cycle is counted after the clear, so it reads 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (clr_overflow)
        r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (clr_overflow) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_sm2201_bus_receiver.sv
// Bench for sm2201_bus_receiver: scoreboard of expected words, compared at each pop.
// Inputs change 2 time units after the rising edge; outputs are read there or on the falling edge.
module tb_sm2201_bus_receiver;

  logic       clk;
  logic       reset;
  logic       e1;
  logic       e2;
  logic [5:0] data;
  logic [5:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] count;
  logic       overflow;
  logic       clr_overflow;
`ifdef SM2201_RX_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0]  sb [$];
  logic [31:0] exp_w;

  sm2201_bus_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .e1           (e1),
    .e2           (e2),
    .data         (data),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef SM2201_RX_DROP_COUNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [5:0] v, input bit exp_push, input int hold);
    data = v;
    if (exp_push)
      sb.push_back(v);
    tick(hold);
  endtask

  task automatic drain(input string tag);
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && rd_valid; i++)
      tick(1);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    rd_ready = 1'b0;
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  // Every accepted pop is checked against the oldest expected word.
  always @(negedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      exp_w = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hFFFF_FFFF;
      chk("pop_data", 32'(rd_data), exp_w);
    end
  end

  initial begin
    reset        = 1'b1;
    e1           = 1'b1;
    e2           = 1'b1;
    data         = 6'h00;
    rd_ready     = 1'b0;
    clr_overflow = 1'b0;
    tick(3);
    reset = 1'b0;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);

    // Window closed: data activity must be ignored.
    for (int v = 1; v <= 5; v++)
      send(6'(v), 1'b0, 10);
    chk("closed_count", 32'(count), 32'd0);
    chk("closed_valid", 32'(rd_valid), 32'd0);
    chk("closed_ovf", 32'(overflow), 32'd0);

    // Open window with a new value: rd_valid on the 6th edge, one word only.
    e1 = 1'b0;
    e2 = 1'b0;
    data = 6'h15;
    sb.push_back(6'h15);
    tick(5);
    chk("lat_edge5_valid", 32'(rd_valid), 32'd0);
    tick(1);
    chk("lat_edge6_valid", 32'(rd_valid), 32'd1);
    chk("lat_edge6_data", 32'(rd_data), 32'h15);
    tick(14);
    chk("hold_once_count", 32'(count), 32'd1);
    drain("d15");

    // Fill past depth: 1..4 kept, 5 dropped.
    for (int v = 1; v <= 5; v++)
      send(6'(v), (v <= 4), 10);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_head", 32'(rd_data), 32'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    drain("dfill");

    // Short glitch must not qualify.
    data = 6'h2A;
    tick(2);
    send(6'h0C, 1'b1, 20);
    chk("glitch_count", 32'(count), 32'd1);
    drain("dglitch");

    // Full FIFO, new word written on the same edge as a pop.
    for (int v = 16; v <= 19; v++)
      send(6'(v), 1'b1, 10);
    chk("cc_full_count", 32'(count), 32'd4);
    data = 6'h14;
    sb.push_back(6'h14);
    tick(5);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    chk("cc_count", 32'(count), 32'd4);
    chk("cc_ovf", 32'(overflow), 32'd0);
    tick(3);
    chk("cc_ovf_later", 32'(overflow), 32'd0);
    drain("dcc");

    // Reset during qualification with three words held.
    for (int v = 32; v <= 34; v++)
      send(6'(v), 1'b1, 10);
    chk("mid_count", 32'(count), 32'd3);
    data = 6'h23;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sb.delete();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    sb.push_back(6'h23);
    tick(5);
    chk("requal_edge5_valid", 32'(rd_valid), 32'd0);
    tick(1);
    chk("requal_edge6_valid", 32'(rd_valid), 32'd1);
    chk("requal_data", 32'(rd_data), 32'h23);
    chk("requal_count", 32'(count), 32'd1);
    drain("dreq");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
